id_bj_resolve: RTL and testbench

- ID-side partner of the fetch stage: consumes the fetch outputs (ia, ia_add4, ir) and drives the fetch redirect (is_bj, bj_addr).
- Holds the IF/ID pipeline register and resolves RV32I branches, JAL and JALR in ID.
- Inserts a one-cycle bubble after every redirect.
- Replays an instruction whose register operands are not ready, by redirecting fetch to the instruction's own address. The fetch stage has no stall input.

---
 rtl/id_bj_resolve.sv | 131 +++++++++++++
 tb/tb_id_bj_resolve.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/id_bj_resolve.sv
// rtl/id_bj_resolve.sv - IF/ID register with ID-stage branch/JAL/JALR resolution and operand-wait replay; BJ_STATS_EN adds redirect counters
module id_bj_resolve #(
    parameter logic [31:0] NOP_INSN = 32'h00000013,  // word loaded for bubbles and at reset
    parameter logic [31:0] RESET_IA = 32'h00000000   // id_ia / id_ia_add4 after reset
) (
    input  logic        clk,         // rising-edge clock
    input  logic        reset,       // synchronous, active-high
    input  logic [31:0] ia,          // fetch address
    input  logic [31:0] ia_add4,     // fetch address + 4
    input  logic [31:0] ir,          // fetched word
    input  logic        rs_ready,    // rs1_data/rs2_data valid for the ID instruction
    input  logic [31:0] rs1_data,    // register read data for rs1_addr
    input  logic [31:0] rs2_data,    // register read data for rs2_addr
    output logic        id_valid,    // ID holds a real instruction
    output logic [31:0] id_ia,       // address of ID instruction
    output logic [31:0] id_ia_add4,  // link value
    output logic [31:0] id_ir,       // ID instruction word
    output logic [4:0]  rs1_addr,    // id_ir[19:15]
    output logic [4:0]  rs2_addr,    // id_ir[24:20]
    output logic        is_bj,       // redirect fetch this cycle
    output logic [31:0] bj_addr,     // redirect target
    output logic [31:0] taken_cnt,   // taken redirects (0 without BJ_STATS_EN)
    output logic [31:0] replay_cnt   // replays (0 without BJ_STATS_EN)
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // IF/ID register; a redirect turns the wrong-path word into a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid   <= 1'b0;
            id_ir      <= NOP_INSN;
            id_ia      <= RESET_IA;
            id_ia_add4 <= RESET_IA;
        end else if (is_bj) begin
            id_valid   <= 1'b0;
            id_ir      <= NOP_INSN;
            id_ia      <= ia;
            id_ia_add4 <= ia_add4;
        end else begin
            id_valid   <= 1'b1;
            id_ir      <= ir;
            id_ia      <= ia;
            id_ia_add4 <= ia_add4;
        end
    end

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic        br_taken;

    assign opcode   = id_ir[6:0];
    assign funct3   = id_ir[14:12];
    assign rs1_addr = id_ir[19:15];
    assign rs2_addr = id_ir[24:20];
    assign imm_i    = {{20{id_ir[31]}}, id_ir[31:20]};
    assign imm_b    = {{20{id_ir[31]}}, id_ir[7], id_ir[30:25], id_ir[11:8], 1'b0};
    assign imm_j    = {{12{id_ir[31]}}, id_ir[19:12], id_ir[20], id_ir[30:21], 1'b0};

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_data == rs2_data);
            3'b001:  br_taken = (rs1_data != rs2_data);
            3'b100:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  br_taken = (rs1_data <  rs2_data);
            3'b111:  br_taken = (rs1_data >= rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    // Operand not ready: redirect fetch back to this instruction so it
    // re-enters ID after the bubble, since fetch cannot be stalled.
    always_comb begin
        is_bj   = 1'b0;
        bj_addr = 32'h0;
        if (id_valid) begin
            case (opcode)
                OP_JAL: begin
                    is_bj   = 1'b1;
                    bj_addr = id_ia + imm_j;
                end
                OP_JALR: begin
                    is_bj   = 1'b1;
                    bj_addr = rs_ready ? ((rs1_data + imm_i) & ~32'h1) : id_ia;
                end
                OP_BRANCH: begin
                    if (!rs_ready) begin
                        is_bj   = 1'b1;
                        bj_addr = id_ia;
                    end else if (br_taken) begin
                        is_bj   = 1'b1;
                        bj_addr = id_ia + imm_b;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BJ_STATS_EN
    logic        replay;
    logic [31:0] taken_q;
    logic [31:0] replay_q;

    assign replay = id_valid && !rs_ready && (opcode == OP_JALR || opcode == OP_BRANCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_q  <= 32'h0;
            replay_q <= 32'h0;
        end else begin
            if (is_bj && !replay) taken_q  <= taken_q + 32'h1;
            if (replay)           replay_q <= replay_q + 32'h1;
        end
    end

    assign taken_cnt  = taken_q;
    assign replay_cnt = replay_q;
`else
    assign taken_cnt  = 32'h0;
    assign replay_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_id_bj_resolve.sv
// tb/tb_id_bj_resolve.sv - scoreboard bench for id_bj_resolve
module tb_id_bj_resolve;

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] ADDI   = 32'h00100093;
    localparam logic [31:0] BEQ8   = 32'h00208463;
    localparam logic [31:0] BLT8   = 32'h0020C463;
    localparam logic [31:0] BGE8   = 32'h0020D463;
    localparam logic [31:0] BLTU8  = 32'h0020E463;
    localparam logic [31:0] BGEU8  = 32'h0020F463;
    localparam logic [31:0] BF2_8  = 32'h0020A463;
    localparam logic [31:0] BNEM4  = 32'hFE209EE3;
    localparam logic [31:0] JALR3  = 32'h003080E7;
    localparam logic [31:0] JAL8   = 32'h0080006F;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ia, ia_add4, ir;
    logic        rs_ready;
    logic [31:0] rs1_data, rs2_data;
    logic        id_valid;
    logic [31:0] id_ia, id_ia_add4, id_ir;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        is_bj;
    logic [31:0] bj_addr, taken_cnt, replay_cnt;

    id_bj_resolve dut (
        .clk(clk), .reset(reset), .ia(ia), .ia_add4(ia_add4), .ir(ir),
        .rs_ready(rs_ready), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .id_valid(id_valid), .id_ia(id_ia), .id_ia_add4(id_ia_add4), .id_ir(id_ir),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .is_bj(is_bj), .bj_addr(bj_addr),
        .taken_cnt(taken_cnt), .replay_cnt(replay_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] ia;
        logic [31:0] ia4;
        logic [31:0] ir;
        logic        rdy;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        bj;
        logic [31:0] addr;
        logic        rep;
        logic        rst;
    } ent_t;

    ent_t prog[$];
    ent_t sb[$];
    int   passes = 0;
    int   total  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%h expected=%h", tag, got, exp);
        else passes++;
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] w, input logic rdy,
                       input logic [31:0] r1, input logic [31:0] r2, input logic bj,
                       input logic [31:0] tgt, input logic rep, input logic rst);
        ent_t s;
        s = '{valid: 1'b1, ia: a, ia4: a + 32'd4, ir: w, rdy: rdy, r1: r1, r2: r2,
              bj: bj, addr: tgt, rep: rep, rst: rst};
        prog.push_back(s);
    endtask

    function automatic ent_t reset_ent();
        reset_ent = '{valid: 1'b0, ia: 32'h0, ia4: 32'h0, ir: NOP, rdy: 1'b0, r1: 32'h0,
                      r2: 32'h0, bj: 1'b0, addr: 32'h0, rep: 1'b0, rst: 1'b0};
    endfunction

    function automatic ent_t bubble_ent(input logic [31:0] a);
        bubble_ent = '{valid: 1'b0, ia: a, ia4: a + 32'd4, ir: NOP, rdy: 1'b0, r1: 32'h0,
                       r2: 32'h0, bj: 1'b0, addr: 32'h0, rep: 1'b0, rst: 1'b0};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired before scoreboard drained");
        $fatal(1);
    end

    initial begin
        ent_t        e;
        ent_t        f;
        logic        used;
        logic [31:0] f_ia, f_ir;
        int          si = 0;
        int          cyc = 0;
        logic [31:0] m_taken = 0;
        logic [31:0] m_replay = 0;

        add(32'h00, ADDI,  1, 0, 0, 0, 0, 0, 0);
        add(32'h04, ADDI,  1, 0, 0, 0, 0, 0, 0);
        add(32'h10, BEQ8,  1, 5, 5, 1, 32'h18, 0, 0);
        add(32'h18, ADDI,  1, 0, 0, 0, 0, 0, 0);
        add(32'h1C, BLT8,  1, 32'hFFFFFFFF, 1, 1, 32'h24, 0, 0);
        add(32'h24, BLTU8, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
        add(32'h28, BGE8,  1, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
        add(32'h2C, BGEU8, 1, 32'hFFFFFFFF, 1, 1, 32'h34, 0, 0);
        add(32'h34, BF2_8, 1, 7, 7, 0, 0, 0, 0);
        add(32'h38, BNEM4, 1, 1, 2, 1, 32'h34, 0, 0);
        add(32'h40, JALR3, 1, 32'h100, 0, 1, 32'h102, 0, 0);
        add(32'h20, BEQ8,  0, 3, 3, 1, 32'h20, 1, 0);
        add(32'h20, BEQ8,  0, 3, 3, 1, 32'h20, 1, 0);
        add(32'h20, BEQ8,  1, 3, 4, 0, 0, 0, 0);
        add(32'h24, BNEM4, 1, 3, 3, 0, 0, 0, 0);
        add(32'h48, JALR3, 0, 0, 0, 1, 32'h48, 1, 0);
        add(32'h48, JALR3, 1, 32'hFFFFFFFE, 0, 1, 32'h0, 0, 0);
        add(32'h00, JAL8,  0, 0, 0, 1, 32'h8, 0, 0);
        add(32'hFFFFFFFC, JAL8, 1, 0, 0, 1, 32'h4, 0, 1);
        add(32'h04, ADDI,  1, 0, 0, 0, 0, 0, 0);
        add(32'h08, ADDI,  1, 0, 0, 0, 0, 0, 0);

        reset    = 1'b1;
        rs_ready = 1'b0;
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        ia       = 32'h100;
        ia_add4  = 32'h104;
        ir       = JAL8;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(reset_ent());

        while (sb.size() > 0 && cyc < 200) begin
            cyc++;
            e = sb.pop_front();
            reset    = e.rst;
            rs_ready = e.rdy;
            rs1_data = e.r1;
            rs2_data = e.r2;
            used     = 1'b0;
            f        = reset_ent();
            if (e.bj || e.rst) begin
                f_ia = e.ia + 32'd4;
                f_ir = JAL8;
            end else if (si < prog.size()) begin
                f    = prog[si];
                si++;
                used = 1'b1;
                f_ia = f.ia;
                f_ir = f.ir;
            end else begin
                f_ia = 32'h200;
                f_ir = NOP;
            end
            ia      = f_ia;
            ia_add4 = f_ia + 32'd4;
            ir      = f_ir;

            @(negedge clk);
            check("id_valid",   {31'h0, id_valid}, {31'h0, e.valid});
            check("id_ia",      id_ia,      e.ia);
            check("id_ia_add4", id_ia_add4, e.ia4);
            check("id_ir",      id_ir,      e.ir);
            check("rs1_addr",   {27'h0, rs1_addr}, {27'h0, e.ir[19:15]});
            check("rs2_addr",   {27'h0, rs2_addr}, {27'h0, e.ir[24:20]});
            check("is_bj",      {31'h0, is_bj}, {31'h0, e.bj});
            check("bj_addr",    bj_addr,    e.addr);
`ifdef BJ_STATS_EN
            check("taken_cnt",  taken_cnt,  m_taken);
            check("replay_cnt", replay_cnt, m_replay);
`else
            check("taken_cnt",  taken_cnt,  32'h0);
            check("replay_cnt", replay_cnt, 32'h0);
`endif
            if (e.rst) begin
                m_taken  = 0;
                m_replay = 0;
            end else if (e.rep) begin
                m_replay = m_replay + 1;
            end else if (e.bj) begin
                m_taken = m_taken + 1;
            end

            if (e.rst)      sb.push_back(reset_ent());
            else if (e.bj)  sb.push_back(bubble_ent(f_ia));
            else if (used)  sb.push_back(f);

            @(posedge clk);
            #1;
        end

        check("steps_consumed", si, prog.size());
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
